// File: rtl/cpu_pkg.sv
// Shared CPU-side types: program-memory FSM states and the default hold length
// used when the loader hands the bus back to the core.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } pm_state_t;

    localparam int PM_RELEASE_CYCLES = 2;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser with asynchronous active-low clear, for
// bringing board-level levels into the system clock domain.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {W{1'b0}};
            q      <= {W{1'b0}};
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/prog_mem.sv
// Synchronous program memory for the CPU fetch port with a switch-driven serial
// loader; holds the CPU off the bus while an image is being written.
module prog_mem
    import cpu_pkg::*;
#(
    parameter int n              = 8,
    parameter int RELEASE_CYCLES = PM_RELEASE_CYCLES
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [n-1:0] MemAddr,
    output logic [n-1:0] MemData,
    input  logic         Load,
    input  logic         LoadStrobe,
    input  logic [n-1:0] LoadData,
    output logic         CpuHold,
    output logic [n-1:0] LoadCount,
    output logic         Overflow
);

    localparam int DEPTH = 2 ** n;
    localparam int RW    = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [RW-1:0] REL_INIT = RW'(RELEASE_CYCLES - 1);

    logic load_s, strobe_s, strobe_q, strobe_edge_s, we_s;
    pm_state_t state_q, state_d;
    logic [RW-1:0] rel_cnt_q, rel_cnt_d;
    logic [n-1:0] mem_data_q, mem_data_d;
    logic [n-1:0] load_count_q, load_count_d;
    logic hold_q, hold_d, overflow_q, overflow_d;
    logic [n-1:0] mem [DEPTH];

    sync2 #(.W(1)) u_sync_load   (.clk(Clock), .rst_n(Reset), .d(Load),       .q(load_s));
    sync2 #(.W(1)) u_sync_strobe (.clk(Clock), .rst_n(Reset), .d(LoadStrobe), .q(strobe_s));

    // Registered copy of the synchronised strobe for rising-edge detection
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_s;
        end
    end

    // A long button press yields a single edge, so it writes only once
    assign strobe_edge_s = strobe_s & ~strobe_q;

    // FSM state and release-counter register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= RELEASE;
            rel_cnt_q <= REL_INIT;
        end else begin
            state_q   <= state_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        rel_cnt_d = rel_cnt_q;
        case (state_q)
            RUN: begin
                if (load_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (!load_s) begin
                    state_d   = RELEASE;
                    rel_cnt_d = REL_INIT;
                end else begin
                    state_d = LOAD;
                end
            end
            RELEASE: begin
                if (rel_cnt_q == {RW{1'b0}}) begin
                    state_d = RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q - RW'(1);
                end
            end
            default: begin
                state_d   = RELEASE;
                rel_cnt_d = REL_INIT;
            end
        endcase
    end

    // Output and loader datapath logic
    always_comb begin
        we_s         = (state_q == LOAD) && strobe_edge_s;
        load_count_d = load_count_q;
        overflow_d   = overflow_q;
        if ((state_q == RUN) && load_s) begin
            load_count_d = {n{1'b0}};
            overflow_d   = 1'b0;
        end else if (we_s) begin
            load_count_d = load_count_q + {{(n-1){1'b0}}, 1'b1};
            if (load_count_q == {n{1'b1}}) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end else begin
            load_count_d = load_count_q;
        end
        if (state_q == RUN) begin
            mem_data_d = mem[MemAddr];
        end else begin
            mem_data_d = {n{1'b0}};
        end
        // Hold is registered from the next state so it drops on the edge entering RUN
        hold_d = (state_d != RUN);
    end

    // Output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mem_data_q   <= {n{1'b0}};
            hold_q       <= 1'b1;
            load_count_q <= {n{1'b0}};
            overflow_q   <= 1'b0;
        end else begin
            mem_data_q   <= mem_data_d;
            hold_q       <= hold_d;
            load_count_q <= load_count_d;
            overflow_q   <= overflow_d;
        end
    end

    // Memory write port; the array is deliberately not reset so images survive Reset
    always_ff @(posedge Clock) begin
        if (we_s) begin
            mem[load_count_q] <= LoadData;
        end
    end

    assign MemData   = mem_data_q;
    assign CpuHold   = hold_q;
    assign LoadCount = load_count_q;
    assign Overflow  = overflow_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed-plus-random bench for prog_mem against an array/counter reference model.
module tb_prog_mem;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       load;
    logic       load_strobe;
    logic [7:0] load_data;
    logic       cpu_hold;
    logic [7:0] load_count;
    logic       overflow;

    logic [7:0] ref_mem [256];
    int         ref_cnt;
    logic       ref_ov;
    int         n_cmp = 0;
    int         n_mis = 0;

    prog_mem #(.n(8), .RELEASE_CYCLES(2)) dut (
        .Clock(clk), .Reset(rst_n), .MemAddr(mem_addr), .MemData(mem_data),
        .Load(load), .LoadStrobe(load_strobe), .LoadData(load_data),
        .CpuHold(cpu_hold), .LoadCount(load_count), .Overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One press/release of the button while in LOAD; model writes at the count
    task automatic strobe(input logic [7:0] d);
        load_data   = d;
        load_strobe = 1'b1;
        repeat (3) tick();
        load_strobe = 1'b0;
        repeat (3) tick();
        ref_mem[ref_cnt] = d;
        if (ref_cnt == 255) ref_ov = 1'b1;
        ref_cnt = (ref_cnt + 1) % 256;
        check("load_count", load_count, 8'(ref_cnt));
        check("overflow", {7'd0, overflow}, {7'd0, ref_ov});
    endtask

    task automatic enter_load;
        load = 1'b1;
        repeat (4) tick();
        ref_cnt = 0;
        ref_ov  = 1'b0;
        check("load_hold", {7'd0, cpu_hold}, 8'd1);
        check("load_cnt_clr", load_count, 8'd0);
        check("load_ov_clr", {7'd0, overflow}, 8'd0);
        check("load_data_zero", mem_data, 8'd0);
    endtask

    // Load falls; hold must stay high through the two release edges, then drop
    task automatic exit_load;
        load = 1'b0;
        repeat (4) tick();
        check("release_hold_hi", {7'd0, cpu_hold}, 8'd1);
        tick();
        check("release_hold_lo", {7'd0, cpu_hold}, 8'd0);
    endtask

    task automatic read_chk(input logic [7:0] a, input string tag);
        mem_addr = a;
        tick();
        check(tag, mem_data, ref_mem[a]);
    endtask

    initial begin
        int k;
        logic [7:0] a;
        rst_n = 1'b0; load = 1'b0; load_strobe = 1'b0; load_data = 8'd0; mem_addr = 8'd0;
        ref_cnt = 0; ref_ov = 1'b0;

        // Reset values and hold release timing
        repeat (3) tick();
        check("rst_memdata", mem_data, 8'd0);
        check("rst_count", load_count, 8'd0);
        check("rst_ov", {7'd0, overflow}, 8'd0);
        check("rst_hold", {7'd0, cpu_hold}, 8'd1);
        rst_n = 1'b1;
        tick();
        check("rst_hold_edge1", {7'd0, cpu_hold}, 8'd1);
        tick();
        check("rst_hold_edge2", {7'd0, cpu_hold}, 8'd0);

        // Wrap: 256 bytes of index, then 0xFF lands on address 0
        enter_load();
        for (int i = 0; i < 256; i++) strobe(8'(i));
        strobe(8'hFF);
        check("wrap_count", load_count, 8'd1);
        check("wrap_ov", {7'd0, overflow}, 8'd1);
        exit_load();
        read_chk(8'd0, "wrap_mem0");
        for (int i = 0; i < 8; i++) read_chk(8'($urandom_range(255, 0)), "wrap_rand");

        // Basic load and readback, address 3 keeps its old value
        enter_load();
        strobe(8'h12); strobe(8'h34); strobe(8'h56);
        check("basic_count", load_count, 8'd3);
        exit_load();
        mem_addr = 8'h01;
        tick();
        check("basic_addr1", mem_data, 8'h34);
        read_chk(8'h03, "basic_addr3_old");
        read_chk(8'h00, "basic_addr0");
        read_chk(8'h02, "basic_addr2");

        // Long press writes exactly once
        enter_load();
        load_data   = 8'hA5;
        load_strobe = 1'b1;
        repeat (10) tick();
        load_strobe = 1'b0;
        repeat (3) tick();
        ref_mem[0] = 8'hA5;
        ref_cnt    = 1;
        check("debounce_count", load_count, 8'd1);
        exit_load();
        read_chk(8'h00, "debounce_mem0");
        read_chk(8'h01, "debounce_mem1");

        // Random image
        enter_load();
        k = $urandom_range(20, 5);
        for (int i = 0; i < k; i++) strobe(8'($urandom));
        exit_load();
        for (int i = 0; i < k; i++) read_chk(8'(i), "rand_img");
        for (int i = 0; i < 8; i++) read_chk(8'($urandom_range(255, 0)), "rand_addr");

        // Reset during a load clears counters but keeps memory
        enter_load();
        strobe(8'h11); strobe(8'h22);
        rst_n = 1'b0;
        #1;
        ref_cnt = 0; ref_ov = 1'b0;
        check("midrst_hold", {7'd0, cpu_hold}, 8'd1);
        check("midrst_count", load_count, 8'd0);
        check("midrst_ov", {7'd0, overflow}, 8'd0);
        load = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("midrst_hold_lo", {7'd0, cpu_hold}, 8'd0);
        read_chk(8'h00, "midrst_mem0");
        read_chk(8'h01, "midrst_mem1");
        check("midrst_mem0_val", ref_mem[0], 8'h11);

        // Strobe in RUN is ignored
        load_data   = ~ref_mem[0];
        load_strobe = 1'b1;
        repeat (3) tick();
        load_strobe = 1'b0;
        repeat (3) tick();
        check("run_strobe_count", load_count, 8'(ref_cnt));
        read_chk(8'h00, "run_strobe_mem0");

        // Strobe during RELEASE is ignored
        enter_load();
        strobe(8'($urandom));
        load = 1'b0;
        tick();
        load_data   = ~ref_mem[ref_cnt];
        load_strobe = 1'b1;
        repeat (3) tick();
        check("rel_strobe_hold_hi", {7'd0, cpu_hold}, 8'd1);
        tick();
        check("rel_strobe_hold_lo", {7'd0, cpu_hold}, 8'd0);
        load_strobe = 1'b0;
        repeat (3) tick();
        check("rel_strobe_count", load_count, 8'(ref_cnt));
        a = 8'(ref_cnt);
        read_chk(a, "rel_strobe_mem");
        read_chk(8'h00, "rel_strobe_mem0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/prog_mem.md
# prog_mem

Synchronous program/data memory that answers the CPU's address-out/data-in fetch interface, with a serial loader. The loader writes a program image byte by byte from board switches while the CPU is held. Sits between `cpu` (drives `MemAddr`, consumes `MemData`) and the board I/O, and replaces the combinational bench RAM in synthesised builds. Also generates the CPU hold that keeps the core quiet while the image changes.

## Interface
- `n`, 8: data and address width; memory depth is 2**n words.
- `RELEASE_CYCLES`, 2: cycles `CpuHold` stays high after reset or after leaving LOAD.
- `Clock`  in  1  single system clock, rising-edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `MemAddr`  in  n  read address from CPU.
- `MemData`  out  n  registered read data to CPU.
- `Load`  in  1  asynchronous level from board switch; high selects load mode.
- `LoadStrobe`  in  1  asynchronous level from board button; each rising edge writes one byte.
- `LoadData`  in  n  byte to write; quasi-static, from switches.
- `CpuHold`  out  1  high while the CPU must not fetch.
- `LoadCount`  out  n  number of bytes written this load, modulo 2**n; equals the next write address.
- `Overflow`  out  1  sticky; set when the write address wraps.

## Operation
- `Load` and `LoadStrobe` each pass through a 2-flop synchroniser. The synchronised strobe is edge-detected against a registered copy.
- FSM states: RUN, LOAD, RELEASE.
  - RUN: `MemData` <= mem[`MemAddr`] every edge; `CpuHold`=0. If synchronised `Load`=1, go to LOAD. On that same edge, clear `LoadCount` and `Overflow`.
  - LOAD: `MemData` <= 0; `CpuHold`=1. On a detected strobe edge: mem[`LoadCount`] <= `LoadData`, then `LoadCount` <= `LoadCount`+1.
    - When `LoadCount`=2**n-1 and a write occurs, `LoadCount` wraps to 0 and `Overflow` <= 1.
    - If synchronised `Load`=0, go to RELEASE with the release counter = `RELEASE_CYCLES`-1. A strobe edge in that same cycle is still written.
  - RELEASE: `CpuHold`=1, `MemData` <= 0. The counter decrements each edge; at 0, go to RUN. Strobe edges are ignored. A reasserted `Load` is ignored until RUN.
- Strobe edges detected in RUN are ignored; no write occurs.
- Strobe held high for many cycles produces exactly one write. Release and re-press are needed for the next write.
- Memory array is not reset; contents survive `Reset`. Power-up contents are undefined unless an init file is used (synthesis attribute, outside this spec).
- Reset (async, `Reset`=0), including mid-load:
  - Go to RELEASE with counter `RELEASE_CYCLES`-1.
  - `MemData`=0, `CpuHold`=1, `LoadCount`=0, `Overflow`=0.
  - Synchroniser and edge flops are cleared to 0.

## Timing
- Read latency is 1 cycle: `MemAddr` stable before edge E gives `MemData` at E.
- Async inputs: a level change sampled at edge E is seen by the FSM at edge E+1 and acts at edge E+2.
  - A strobe rise sampled at E writes at E+2.
  - `LoadData` must be stable from E to E+2.
- The LOAD-to-RUN transition is decided at edge E+2 after the `Load` fall. After that, `CpuHold` stays high for `RELEASE_CYCLES` edges and is 0 after the last one. The first valid `MemData` is one edge later.
- After `Reset` deasserts, `CpuHold` falls after `RELEASE_CYCLES` rising edges.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- `cpu_pkg` gains:
  - `typedef enum logic [1:0] {RUN, LOAD, RELEASE} pm_state_t`
  - the default `RELEASE_CYCLES` constant
- Sub-module `sync2` is a generic 2-flop synchroniser with async active-low clear. It is instantiated twice, for `Load` and `LoadStrobe`, and can be reused for `Switches` in the CPU.
- Memory is a single inferred 2**n × n array with a synchronous write port and a synchronous read port.

## Test plan
- **Reset:** hold `Reset`=0 for 3 cycles, then release. Expect `MemData`=0x00, `LoadCount`=0, `Overflow`=0 and `CpuHold`=1 during reset. `CpuHold` is 0 after exactly 2 edges.
- **Load and read back:**
  - Raise `Load`, then pulse `LoadStrobe` with `LoadData`=0x12, 0x34, 0x56. Expect `LoadCount`=3.
  - Drop `Load` and wait for `CpuHold`=0. Drive `MemAddr`=0x01; expect `MemData`=0x34 on the next edge. Drive 0x03; expect the old contents of address 3 to be unchanged.
- **Debounce contract:** in LOAD, hold `LoadStrobe` high for 10 cycles with `LoadData`=0xA5. Expect exactly one write and `LoadCount` +1.
- **Wrap:** 257 strobes with `LoadData`=index mod 256, last byte 0xFF. Expect `Overflow`=1, `LoadCount`=1 and mem[0]=0xFF.
- **Reset mid-load:**
  - Write 0x11, 0x22, then assert `Reset`. Expect `CpuHold`=1, `LoadCount`=0 and `Overflow`=0.
  - After release with `Load`=0, reads of addresses 0 and 1 return 0x11 and 0x22.
- **Ignored strobes:** a strobe edge in RUN or RELEASE writes nothing. Reading the target address returns its prior value.
